// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
// Used by the slave interface decode and the APB controller.
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_RENABLE  = 3'd3,
    ST_WRITE    = 3'd4,
    ST_WENABLE  = 3'd5,
    ST_WRITEP   = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  localparam logic [2:0] SEL_P0 = 3'b001;
  localparam logic [2:0] SEL_P1 = 3'b010;
  localparam logic [2:0] SEL_P2 = 3'b100;

  localparam logic [31:0] MAP_P0_LO = 32'h8000_0000;
  localparam logic [31:0] MAP_P1_LO = 32'h8400_0000;
  localparam logic [31:0] MAP_P2_LO = 32'h8800_0000;
  localparam logic [31:0] MAP_HI    = 32'h8C00_0000;

  function automatic logic [2:0] decode_sel(input logic [31:0] addr);
    if (addr >= MAP_P0_LO && addr < MAP_P1_LO) return SEL_P0;
    if (addr >= MAP_P1_LO && addr < MAP_P2_LO) return SEL_P1;
    if (addr >= MAP_P2_LO && addr < MAP_HI)    return SEL_P2;
    return 3'b000;
  endfunction

endpackage

// File: rtl/apb_controller.sv
// APB phase sequencer of the AHB-to-APB bridge.
// Posted writes plus one pending transfer behind an in-flight write.
module apb_controller
  import ahb2apb_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        valid,
  input  logic        Hwrite,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [2:0]  tempselx,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Hreadyout
);

  state_t      state;
  state_t      nxt;
  logic        accept;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [2:0]  sel_q;

  logic [2:0]  sel_d;
  logic        en_d;
  logic        wr_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic        rdy_d;

  assign accept = valid & Hreadyout;

  always_comb begin
    nxt = ST_IDLE;
    unique case (state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (accept) nxt = Hwrite ? ST_WWAIT : ST_READ;
      end
      ST_WWAIT:    nxt = accept ? ST_WRITEP : ST_WRITE;
      ST_READ:     nxt = ST_RENABLE;
      ST_WRITE:    nxt = ST_WENABLE;
      ST_WRITEP:   nxt = ST_WENABLEP;
      ST_WENABLEP: nxt = wr_q ? ST_WRITE : ST_READ;
    endcase
  end

  // Outputs are registered: they take the value of the state being entered.
  always_comb begin
    sel_d   = Pselx;
    en_d    = 1'b0;
    wr_d    = Pwrite;
    addr_d  = Paddr;
    wdata_d = Pwdata;
    rdy_d   = 1'b1;
    unique case (nxt)
      ST_IDLE, ST_WWAIT: begin
        sel_d = 3'b000;
      end
      ST_READ: begin
        sel_d  = (state == ST_WENABLEP) ? sel_q : tempselx;
        addr_d = (state == ST_WENABLEP) ? addr_q : Haddr;
        wr_d   = 1'b0;
        rdy_d  = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = Hwdata;
        wr_d    = 1'b1;
        rdy_d   = 1'b0;
      end
      ST_RENABLE, ST_WENABLE: begin
        en_d = 1'b1;
      end
      ST_WENABLEP: begin
        en_d  = 1'b1;
        rdy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      Pselx     <= 3'b000;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= 32'h0;
      Pwdata    <= 32'h0;
      Hreadyout <= 1'b1;
    end else begin
      state     <= nxt;
      Pselx     <= sel_d;
      Penable   <= en_d;
      Pwrite    <= wr_d;
      Paddr     <= addr_d;
      Pwdata    <= wdata_d;
      Hreadyout <= rdy_d;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_q <= 32'h0;
      wr_q   <= 1'b0;
      sel_q  <= 3'b000;
    end else if (accept) begin
      addr_q <= Haddr;
      wr_q   <= Hwrite;
      sel_q  <= tempselx;
    end
  end

endmodule
